// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding imem word request, buffers the returned
// instruction for decode, and takes PC redirects. Optional macro: IFU_MISALIGN_EN.
module ifu #(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            misalign_o
);

    localparam logic [XLEN-1:0] RST_PC = XLEN'(RESET_PC);

`ifdef IFU_MISALIGN_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
`endif

    state_t          state, state_d;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            drop_q;
    logic            req_valid_q;
    logic            instr_valid_q;
    logic            redirect_ok;
    logic [XLEN-1:0] redirect_tgt;

`ifdef IFU_MISALIGN_EN
    logic misalign_q;
    logic redirect_bad;

    // HALT ignores redirects entirely; only rst leaves it.
    assign redirect_ok  = redirect_valid_i && (state != S_HALT);
    assign redirect_tgt = redirect_pc_i;
    assign redirect_bad = redirect_ok && (redirect_pc_i[1:0] != 2'b00);
    assign misalign_o   = misalign_q;
`else
    logic unused_redirect_lsbs;

    assign redirect_ok          = redirect_valid_i;
    assign redirect_tgt         = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
    assign misalign_o           = 1'b0;
`endif

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: state_d = S_REQ;
            S_REQ:  if (imem_req_ready) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_resp_valid)
                    state_d = (drop_q || redirect_ok) ? S_REQ : S_HOLD;
            end
            S_HOLD: if (redirect_ok || instr_ready_i) state_d = S_REQ;
`ifdef IFU_MISALIGN_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef IFU_MISALIGN_EN
        if (redirect_bad)
            state_d = S_HALT;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            pc_q          <= RST_PC;
            instr_q       <= '0;
            drop_q        <= 1'b0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
`ifdef IFU_MISALIGN_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            state         <= state_d;
            req_valid_q   <= (state_d == S_REQ);
            instr_valid_q <= (state_d == S_HOLD);

            // A redirect coinciding with the HOLD handshake wins over pc+4.
            if (redirect_ok)
                pc_q <= redirect_tgt;
            else if (state == S_HOLD && instr_ready_i)
                pc_q <= pc_q + XLEN'(4);

            case (state)
                S_REQ: begin
                    if (imem_req_ready)
                        drop_q <= redirect_ok;
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        drop_q <= 1'b0;
                        if (!drop_q && !redirect_ok)
                            instr_q <= imem_resp_data;
                    end else if (redirect_ok) begin
                        drop_q <= 1'b1;
                    end
                end
                default: ;
            endcase

`ifdef IFU_MISALIGN_EN
            if (redirect_bad) begin
                misalign_q <= 1'b1;
                drop_q     <= 1'b0;
            end
`endif
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign instr_valid_o  = instr_valid_q;
    assign instr_o        = instr_q;
    assign pc_o           = pc_q;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed cycle table, reset/misalign sequences,
// and a randomized run against a transaction-level fetch model.
module tb_ifu;

    localparam logic [31:0] RP  = 32'h8000_0000;
    localparam logic [31:0] D0  = 32'h0010_0093;
    localparam logic [31:0] D1  = 32'h0020_0113;
    localparam logic [31:0] D2  = 32'h0030_0193;
    localparam logic [31:0] D3  = 32'h0040_0213;
    localparam logic [31:0] DS  = 32'hDEAD_BEEF;
    localparam logic [31:0] DS2 = 32'hBADC_0FFE;
    localparam logic [31:0] T1  = 32'h8000_1000;
    localparam logic [31:0] T2  = 32'h8000_2000;
    localparam logic [31:0] T3  = 32'h8000_3000;
    localparam logic [31:0] T4  = 32'h8000_4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        misalign_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    ifu #(.XLEN(32), .RESET_PC(RP)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .pc_o             (pc_o),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .misalign_o       (misalign_o)
    );

    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] rd;
        logic        ir, redv;
        logic [31:0] redpc;
        logic        e_rqv, e_iv;
        logic [31:0] e_instr, e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                         input logic ir, input logic redv, input logic [31:0] redpc);
        rst              = r;
        imem_req_ready   = rdy;
        imem_resp_valid  = rv;
        imem_resp_data   = rd;
        instr_ready_i    = ir;
        redirect_valid_i = redv;
        redirect_pc_i    = redpc;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic ir, input logic redv, input logic [31:0] redpc,
                       input logic e_rqv, input logic e_iv, input logic [31:0] e_instr,
                       input logic [31:0] e_pc);
        vec_t v;
        v = '{r, rdy, rv, rd, ir, redv, redpc, e_rqv, e_iv, e_instr, e_pc};
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Randomized-phase model state
    logic [31:0] exp_pc;
    logic        mem_busy, stale, deliver_due, req_due, prev_iv;
    int unsigned mem_cnt;
    logic [31:0] mem_addr;
    int unsigned deliveries;

    initial begin
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        next_cycle();
        next_cycle();

        //   rst rdy rv  rd   ir  redv redpc   rqv iv  instr pc
        add(1, 0, 0, 0,   0, 0, 0,    0, 0, 0,  RP);
        add(0, 1, 0, 0,   0, 0, 0,    0, 0, 0,  RP);
        add(0, 1, 0, 0,   0, 0, 0,    1, 0, 0,  RP);
        add(0, 0, 1, D0,  0, 0, 0,    0, 0, 0,  RP);
        add(0, 1, 0, 0,   1, 0, 0,    0, 1, D0, RP);
        add(0, 1, 0, 0,   0, 0, 0,    1, 0, D0, RP + 4);
        add(0, 0, 1, D1,  0, 0, 0,    0, 0, D0, RP + 4);
        for (int i = 0; i < 5; i++)
            add(0, 1, 0, 0, 0, 0, 0,  0, 1, D1, RP + 4);
        add(0, 0, 0, 0,   1, 0, 0,    0, 1, D1, RP + 4);
        add(0, 0, 0, 0,   0, 0, 0,    1, 0, D1, RP + 8);
        add(0, 1, 0, 0,   0, 0, 0,    1, 0, D1, RP + 8);
        add(0, 0, 1, D2,  0, 0, 0,    0, 0, D1, RP + 8);
        add(0, 0, 0, 0,   1, 1, T2,   0, 1, D2, RP + 8);
        add(0, 1, 0, 0,   0, 0, 0,    1, 0, D2, T2);
        add(0, 0, 0, 0,   0, 1, T1,   0, 0, D2, T2);
        add(0, 0, 0, 0,   0, 0, 0,    0, 0, D2, T1);
        add(0, 0, 0, 0,   0, 0, 0,    0, 0, D2, T1);
        add(0, 0, 1, DS,  0, 0, 0,    0, 0, D2, T1);
        add(0, 1, 0, 0,   0, 0, 0,    1, 0, D2, T1);
        add(0, 0, 1, D3,  0, 0, 0,    0, 0, D2, T1);
        add(0, 0, 0, 0,   1, 0, 0,    0, 1, D3, T1);
        add(0, 1, 0, 0,   0, 1, T3,   1, 0, D3, T1 + 4);
        add(0, 0, 1, DS2, 0, 0, 0,    0, 0, D3, T3);
        add(0, 0, 0, 0,   0, 0, 0,    1, 0, D3, T3);
        add(0, 0, 0, 0,   0, 1, T4,   1, 0, D3, T3);
        add(0, 0, 0, 0,   0, 0, 0,    1, 0, D3, T4);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rd,
                  vecs[i].ir, vecs[i].redv, vecs[i].redpc);
            @(negedge clk);
            check($sformatf("row%0d req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_rqv));
            check($sformatf("row%0d req_addr", i),  imem_req_addr,       vecs[i].e_pc);
            check($sformatf("row%0d instr_valid", i), 32'(instr_valid_o), 32'(vecs[i].e_iv));
            check($sformatf("row%0d instr", i),     instr_o,             vecs[i].e_instr);
            check($sformatf("row%0d pc", i),        pc_o,                vecs[i].e_pc);
            check($sformatf("row%0d misalign", i),  32'(misalign_o),     32'd0);
            next_cycle();
        end

        // Reset pulsed mid-WAIT
        begin
            int unsigned first_req;
            drive(0, 1, 0, 0, 0, 0, 0);
            @(negedge clk);
            check("rstwait pre req_valid", 32'(imem_req_valid), 32'd1);
            next_cycle();
            drive(1, 0, 0, 0, 0, 0, 0);
            next_cycle();
            drive(0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            check("rstwait req_valid", 32'(imem_req_valid), 32'd0);
            check("rstwait req_addr",  imem_req_addr,       RP);
            check("rstwait instr_valid", 32'(instr_valid_o), 32'd0);
            check("rstwait instr",     instr_o,             32'd0);
            check("rstwait pc",        pc_o,                RP);
            first_req = 0;
            for (int unsigned n = 1; n <= 8; n++) begin
                if (n > 1) @(negedge clk);
                if (imem_req_valid && first_req == 0) first_req = n;
                next_cycle();
            end
            check("rstwait first_req_cycle", first_req, 32'd2);
        end

        // Misaligned redirect while in REQ at RP
        drive(0, 0, 0, 0, 0, 1, 32'h8000_0002);
        next_cycle();
`ifdef IFU_MISALIGN_EN
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0, 1, (i == 2), RP);
            @(negedge clk);
            check($sformatf("halt%0d misalign", i), 32'(misalign_o), 32'd1);
            check($sformatf("halt%0d req_valid", i), 32'(imem_req_valid), 32'd0);
            check($sformatf("halt%0d instr_valid", i), 32'(instr_valid_o), 32'd0);
            check($sformatf("halt%0d pc", i), pc_o, 32'h8000_0002);
            next_cycle();
        end
`else
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("misredir req_valid", 32'(imem_req_valid), 32'd1);
        check("misredir req_addr",  imem_req_addr,       RP);
        check("misredir misalign",  32'(misalign_o),     32'd0);
        next_cycle();
`endif

        // Randomized run against a fetch-order model
        drive(1, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        exp_pc = RP; mem_busy = 0; stale = 0; deliver_due = 0; req_due = 0; prev_iv = 0;
        mem_cnt = 0; mem_addr = '0; deliveries = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic        rv, rdy, ir, redv, rising;
            logic [31:0] rd, redpc;
            rv = 1'b0;
            if (mem_busy) begin
                mem_cnt--;
                rv = (mem_cnt == 0);
            end
            rd    = rv ? mem_word(mem_addr) : $urandom;
            rdy   = 1'($urandom_range(0, 1));
            ir    = ($urandom_range(0, 99) < 60);
            redv  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) redpc = 32'hFFFF_FFF8;
            else redpc = RP + {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
`ifndef IFU_MISALIGN_EN
            redpc[1:0] = 2'($urandom_range(0, 3));
`endif
            drive(0, rdy, rv, rd, ir, redv, redpc);
            @(negedge clk);

            check("rand req_addr", imem_req_addr, exp_pc);
            check("rand pc", pc_o, exp_pc);
            check("rand misalign", 32'(misalign_o), 32'd0);
            if (instr_valid_o) check("rand instr", instr_o, mem_word(exp_pc));
            rising = instr_valid_o && !prev_iv;
            check("rand deliver_timing", 32'(rising), 32'(deliver_due));
            if (req_due) check("rand req_after_event", 32'(imem_req_valid), 32'd1);
            check("rand single_outstanding", 32'(imem_req_valid && mem_busy), 32'd0);

            deliver_due = rv && !stale && !redv;
            req_due     = (instr_valid_o && (ir || redv)) || (rv && (stale || redv));
            if (rv) mem_busy = 1'b0;
            if (imem_req_valid && rdy) begin
                mem_busy = 1'b1;
                mem_cnt  = $urandom_range(1, 4);
                mem_addr = imem_req_addr;
                stale    = redv;
            end else if (mem_busy && redv) begin
                stale = 1'b1;
            end
            if (instr_valid_o && ir) deliveries++;
            if (redv) exp_pc = {redpc[31:2], 2'b00};
            else if (instr_valid_o && ir) exp_pc = exp_pc + 32'd4;
            prev_iv = instr_valid_o;
            next_cycle();
        end
        check("rand progress", 32'(deliveries > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
